// File: rtl/picosoc_bus_fabric.sv
// Memory-bus fabric for the picorv32 native interface: integrated SRAM, NUM_SLAVES decoded slave
// windows and a bus-timeout watchdog. Define PICOSOC_FABRIC_XPROT_EN to refuse fetches from slaves.
module picosoc_bus_fabric #(
   parameter int                         NUM_SLAVES = 4,
   parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE   = {32'h0300_0000, 32'h0200_0000,
                                                       32'h0100_0000, 32'h0010_0000},
   parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK   = {4{32'hFF00_0000}},
   parameter int                         MEM_WORDS  = 256,
   parameter int                         RAM_WAIT   = 0,
   parameter int                         TIMEOUT    = 255,
   parameter logic [31:0]                ERR_DATA   = 32'hDEAD_BEEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_valid,
   input  logic                     mem_instr,
   input  logic [31:0]              mem_addr,
   input  logic [31:0]              mem_wdata,
   input  logic [3:0]               mem_wstrb,
   output logic                     mem_ready,
   output logic [31:0]              mem_rdata,
   output logic [NUM_SLAVES-1:0]    s_valid,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [NUM_SLAVES-1:0]    s_ready,
   input  logic [32*NUM_SLAVES-1:0] s_rdata,
   output logic                     irq_timeout,
   output logic [31:0]              err_addr
);

   localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);
   localparam logic [NUM_SLAVES-1:0] SV_ONE = NUM_SLAVES'(1);

   typedef enum logic [1:0] {IDLE, RAM, SLV, ERR} state_t;

   state_t        state, state_next;
   logic [7:0]    cnt, cnt_next;
   logic [SW-1:0] sel_q, slv_idx;
   logic          ram_hit, slv_hit, slv_ok, accept;
   logic          done_ram, done_slv, done_err;
   logic [31:0]   ram [MEM_WORDS];

   assign accept  = (state == IDLE) && mem_valid && !mem_ready;
   assign ram_hit = (mem_addr < RAM_BYTES);

   // Lowest-index window wins, so scan downwards and let later hits overwrite.
   always_comb begin
      slv_hit = 1'b0;
      slv_idx = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
         if ((mem_addr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32]) begin
            slv_hit = 1'b1;
            slv_idx = SW'(k);
         end
      end
   end

`ifdef PICOSOC_FABRIC_XPROT_EN
   assign slv_ok = slv_hit && !mem_instr;
`else
   logic unused_instr;
   assign unused_instr = mem_instr;
   assign slv_ok       = slv_hit;
`endif

   // One counter serves both the SRAM wait states and the slave watchdog; it is cleared on accept.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done_ram   = 1'b0;
      done_slv   = 1'b0;
      done_err   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_next = '0;
               if (ram_hit)     state_next = RAM;
               else if (slv_ok) state_next = SLV;
               else             state_next = ERR;
            end
         end
         RAM: begin
            if (cnt == 8'(RAM_WAIT)) begin
               done_ram   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         SLV: begin
            if (s_ready[sel_q]) begin
               done_slv   = 1'b1;
               state_next = IDLE;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               state_next = ERR;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         ERR: begin
            done_err   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // SRAM contents survive reset; byte lanes commit on the accept edge.
   always_ff @(posedge clk) begin
      if (!reset && accept && ram_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_wstrb[b]) ram[mem_addr[AW+1:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // The slave-side address register doubles as the latched request address for SRAM and errors.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_ready   <= 1'b0;
         mem_rdata   <= '0;
         s_valid     <= '0;
         s_addr      <= '0;
         s_wdata     <= '0;
         s_wstrb     <= '0;
         sel_q       <= '0;
         irq_timeout <= 1'b0;
         err_addr    <= '0;
      end else begin
         mem_ready   <= done_ram | done_slv | done_err;
         irq_timeout <= done_err;
         if (accept) begin
            s_addr  <= mem_addr;
            s_wdata <= mem_wdata;
            s_wstrb <= mem_wstrb;
            sel_q   <= slv_idx;
         end
         if (accept && !ram_hit && slv_ok) s_valid <= SV_ONE << slv_idx;
         else if (state == SLV && state_next != SLV) s_valid <= '0;
         if (done_ram) mem_rdata <= ram[s_addr[AW+1:2]];
         if (done_slv) mem_rdata <= s_rdata[32*sel_q +: 32];
         if (done_err) begin
            mem_rdata <= ERR_DATA;
            err_addr  <= s_addr;
         end
      end
   end

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Self-checking bench for picosoc_bus_fabric: a table of bus accesses checked through an
// expectation queue, plus hand-written reset and wait-state sequences.
module tb_picosoc_bus_fabric;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        instr;
      int          slvSel;
      int          slvDelay;
      logic [31:0] slvData;
      int          expLat;
      logic        chkRdata;
      logic [31:0] expRdata;
      logic        expIrq;
      logic [31:0] expErrAddr;
      logic [3:0]  expSv;
      int          expSvCyc;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic mem_valid, mem_instr, useB;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic valid_a, valid_b;
   logic ready_a, ready_b, irq_a, irq_b;
   logic [31:0] rdata_a, rdata_b, saddr_a, saddr_b, swdata_a, swdata_b, erraddr_a, erraddr_b;
   logic [3:0]  sv_a, sv_b, swstrb_a, swstrb_b, s_ready, sready_b;
   logic [127:0] s_rdata, srdata_b;
   logic rdyM, irqM;
   logic [31:0] rdataM, errM;
   logic [3:0] svM;

   int slvSel, slvDelay;
   logic [31:0] slvData;
   int checks = 0;
   int errors = 0;
   vec_t expQ[$];

   always #5 clk = ~clk;

   assign valid_a = mem_valid & ~useB;
   assign valid_b = mem_valid & useB;
   assign rdyM    = useB ? ready_b   : ready_a;
   assign irqM    = useB ? irq_b     : irq_a;
   assign rdataM  = useB ? rdata_b   : rdata_a;
   assign errM    = useB ? erraddr_b : erraddr_a;
   assign svM     = useB ? sv_b      : sv_a;

   picosoc_bus_fabric #(
      .SLV_MASK ({32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFFF0_0000}),
      .RAM_WAIT (0),
      .TIMEOUT  (16)
   ) dutA (
      .clk(clk), .reset(reset), .mem_valid(valid_a), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(ready_a), .mem_rdata(rdata_a), .s_valid(sv_a), .s_addr(saddr_a),
      .s_wdata(swdata_a), .s_wstrb(swstrb_a), .s_ready(s_ready), .s_rdata(s_rdata),
      .irq_timeout(irq_a), .err_addr(erraddr_a)
   );

   picosoc_bus_fabric #(
      .RAM_WAIT (3)
   ) dutB (
      .clk(clk), .reset(reset), .mem_valid(valid_b), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(ready_b), .mem_rdata(rdata_b), .s_valid(sv_b), .s_addr(saddr_b),
      .s_wdata(swdata_b), .s_wstrb(swstrb_b), .s_ready(sready_b), .s_rdata(srdata_b),
      .irq_timeout(irq_b), .err_addr(erraddr_b)
   );

   // Slave model: the selected slave answers slvDelay cycles into s_valid, the others keep
   // their ready lines high so a fabric that listens to the wrong slave finishes early.
   initial begin
      int holdCnt;
      holdCnt = 0;
      s_ready = '0;
      s_rdata = '0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 4; k++)
            s_rdata[32*k +: 32] = (k == slvSel) ? slvData : 32'h0BAD_0000 + 32'(k);
         s_ready = ~(4'b0001 << slvSel);
         if (sv_a != '0) begin
            holdCnt++;
            if (slvDelay >= 0 && holdCnt == slvDelay + 1) s_ready[slvSel] = 1'b1;
         end else begin
            holdCnt = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", what, act, req);
      end
   endtask

   function automatic vec_t mkVec(input string name, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  input logic instr, input int sel, input int dly,
                                  input logic [31:0] data, input int lat, input logic chk,
                                  input logic [31:0] rd, input logic irq,
                                  input logic [31:0] ea, input logic [3:0] sv, input int cyc);
      vec_t v;
      v.name = name; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.instr = instr;
      v.slvSel = sel; v.slvDelay = dly; v.slvData = data; v.expLat = lat; v.chkRdata = chk;
      v.expRdata = rd; v.expIrq = irq; v.expErrAddr = ea; v.expSv = sv; v.expSvCyc = cyc;
      return v;
   endfunction

   task automatic checkOutput(input int lat, input int svCyc, input logic [3:0] svOr,
                              input logic busBad);
      vec_t e;
      if (expQ.size() == 0) begin
         check("scoreboard_empty", 32'(expQ.size()), 1);
      end else begin
         e = expQ.pop_front();
         check({e.name, " latency"}, 32'(lat), 32'(e.expLat));
         if (e.chkRdata) check({e.name, " rdata"}, rdataM, e.expRdata);
         check({e.name, " irq"}, 32'(irqM), 32'(e.expIrq));
         check({e.name, " err_addr"}, errM, e.expErrAddr);
         check({e.name, " s_valid_seen"}, 32'(svOr), 32'(e.expSv));
         check({e.name, " s_valid_cycles"}, 32'(svCyc), 32'(e.expSvCyc));
         if (e.expSv != '0) check({e.name, " slave_bus_stable"}, 32'(busBad), 0);
      end
   endtask

   // Drives one request, follows it until mem_ready (bounded), then checks the single-cycle pulse.
   task automatic applyStimulus(input vec_t v);
      int lat, svCyc;
      logic [3:0] svOr;
      logic busBad;
      expQ.push_back(v);
      @(negedge clk);
      slvSel = v.slvSel; slvDelay = v.slvDelay; slvData = v.slvData;
      mem_addr = v.addr; mem_wdata = v.wdata; mem_wstrb = v.wstrb; mem_instr = v.instr;
      mem_valid = 1'b1;
      @(posedge clk);
      #1;
      lat = 0; svCyc = 0; svOr = '0; busBad = 1'b0;
      while (!rdyM && lat < 40) begin
         if (svM != '0) begin
            svCyc++;
            svOr |= svM;
            if (saddr_a != v.addr || swdata_a != v.wdata || swstrb_a != v.wstrb) busBad = 1'b1;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      mem_valid = 1'b0;
      checkOutput(lat, svCyc, svOr, busBad);
      @(posedge clk);
      #1;
      check({v.name, " ready_pulse_width"}, 32'(rdyM), 0);
      check({v.name, " irq_pulse_width"}, 32'(irqM), 0);
   endtask

   task automatic resetMidUnmapped();
      @(negedge clk);
      mem_addr = 32'h8000_0000; mem_wdata = 32'h1; mem_wstrb = 4'hF; mem_instr = 1'b0;
      mem_valid = 1'b1;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rst_unmapped ready", 32'(ready_a), 0);
         check("rst_unmapped irq", 32'(irq_a), 0);
         @(posedge clk);
         #1;
      end
      check("rst_unmapped err_addr", erraddr_a, 32'h0);
   endtask

   task automatic resetMidSlave();
      @(negedge clk);
      slvSel = 1; slvDelay = -1; slvData = 32'h0;
      mem_addr = 32'h0100_0004; mem_wdata = 32'h0; mem_wstrb = 4'h0; mem_instr = 1'b0;
      mem_valid = 1'b1;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_slave s_valid_before", 32'(sv_a), 32'h2);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_slave s_valid_after", 32'(sv_a), 32'h0);
      for (int i = 0; i < 3; i++) begin
         check("rst_slave ready", 32'(ready_a), 0);
         check("rst_slave irq", 32'(irq_a), 0);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      vec_t vecs[$];
      useB = 1'b0; reset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
      slvSel = 0; slvDelay = -1; slvData = '0; sready_b = '0; srdata_b = '0;

      //               name                   addr          wdata         strb   ins sel dly data          lat chk rdata         irq err_addr      sv      cyc
      vecs.push_back(mkVec("ram_wr_full",     32'h0000_0010, 32'h1234_5678, 4'hF, 0, 0, -1, 32'h0,         1, 0, 32'h0,         0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("ram_wr_byte",     32'h0000_0010, 32'h0000_00AA, 4'h1, 0, 0, -1, 32'h0,         1, 0, 32'h0,         0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("ram_rd",          32'h0000_0010, 32'h0,         4'h0, 0, 0, -1, 32'h0,         1, 1, 32'h1234_56AA, 0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("ram_fetch",       32'h0000_0010, 32'h0,         4'h0, 1, 0, -1, 32'h0,         1, 1, 32'h1234_56AA, 0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("ram_top_wr",      32'h0000_03FC, 32'hFEED_F00D, 4'hF, 0, 0, -1, 32'h0,         1, 0, 32'h0,         0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("ram_top_rd",      32'h0000_03FC, 32'h0,         4'h0, 0, 0, -1, 32'h0,         1, 1, 32'hFEED_F00D, 0, 32'h0,         4'h0, 0));
      vecs.push_back(mkVec("slv2_rd",         32'h0200_0008, 32'h0,         4'h0, 0, 2,  5, 32'hCAFE_0001, 6, 1, 32'hCAFE_0001, 0, 32'h0,         4'h4, 6));
      vecs.push_back(mkVec("slv3_wr",         32'h0300_0010, 32'h0000_55AA, 4'h3, 0, 3,  0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         4'h8, 1));
      vecs.push_back(mkVec("slv1_timeout",    32'h0100_0004, 32'h0,         4'h0, 0, 1, -1, 32'h0,        17, 1, 32'hDEAD_BEEF, 1, 32'h0100_0004, 4'h2, 16));
      vecs.push_back(mkVec("slv1_ready_limit",32'h0100_0008, 32'h0,         4'h0, 0, 1, 15, 32'h1111_2222,16, 1, 32'h1111_2222, 0, 32'h0100_0004, 4'h2, 16));
      vecs.push_back(mkVec("unmapped_wr",     32'h8000_0000, 32'h0000_0001, 4'hF, 0, 0, -1, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 32'h8000_0000, 4'h0, 0));
      vecs.push_back(mkVec("above_ram",       32'h0000_0400, 32'h0,         4'h0, 0, 0, -1, 32'h0,         1, 1, 32'hDEAD_BEEF, 1, 32'h0000_0400, 4'h0, 0));
`ifdef PICOSOC_FABRIC_XPROT_EN
      vecs.push_back(mkVec("fetch_slv0",      32'h0010_0000, 32'h0,         4'h0, 1, 0,  2, 32'h00C0_FFEE, 1, 1, 32'hDEAD_BEEF, 1, 32'h0010_0000, 4'h0, 0));
      vecs.push_back(mkVec("data_slv0",       32'h0010_0010, 32'h0,         4'h0, 0, 0,  1, 32'h0BEE_0010, 2, 1, 32'h0BEE_0010, 0, 32'h0010_0000, 4'h1, 2));
`else
      vecs.push_back(mkVec("fetch_slv0",      32'h0010_0000, 32'h0,         4'h0, 1, 0,  2, 32'h00C0_FFEE, 3, 1, 32'h00C0_FFEE, 0, 32'h0000_0400, 4'h1, 3));
      vecs.push_back(mkVec("data_slv0",       32'h0010_0010, 32'h0,         4'h0, 0, 0,  1, 32'h0BEE_0010, 2, 1, 32'h0BEE_0010, 0, 32'h0000_0400, 4'h1, 2));
`endif

      repeat (3) @(posedge clk);
      #1;
      check("reset mem_ready", 32'(ready_a), 0);
      check("reset mem_rdata", rdata_a, 32'h0);
      check("reset s_valid", 32'(sv_a), 0);
      check("reset s_addr", saddr_a, 32'h0);
      check("reset s_wdata", swdata_a, 32'h0);
      check("reset s_wstrb", 32'(swstrb_a), 0);
      check("reset irq", 32'(irq_a), 0);
      check("reset err_addr", erraddr_a, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

      resetMidUnmapped();
      resetMidSlave();

      useB = 1'b1;
      applyStimulus(mkVec("wait3_wr", 32'h0, 32'hA5A5_5A5A, 4'hF, 0, 0, -1, 32'h0, 4, 0, 32'h0,         0, 32'h0, 4'h0, 0));
      applyStimulus(mkVec("wait3_rd", 32'h0, 32'h0,         4'h0, 0, 0, -1, 32'h0, 4, 1, 32'hA5A5_5A5A, 0, 32'h0, 4'h0, 0));
      useB = 1'b0;

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
